tq_path_ctl: RTL and testbench
==============================

TQ_PATH_CTL -- requirements
Module: tq_path_ctl

Interface
REQ-001 SHALL have parameter N_PATH, default 2: number of destination paths; N_PATH=2 gives path 0 = inverse mux, path 1 = forward pe.
REQ-002 SHALL have parameter DATA_W, default 256: row payload width.
REQ-003 SHALL have parameter CNT_W, default 5: row-counter width; max block = 2^CNT_W rows.
REQ-004 SHALL derive localparam SEL_W = max(1, clog2(N_PATH)).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rstn  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  block-start pulse; latches i_sel and i_rows.
REQ-008 i_sel  in  SEL_W  destination path index for the block.
REQ-009 i_rows  in  CNT_W  block row count minus 1.
REQ-010 i_valid  in  1  upstream row valid.
REQ-011 i_data  in  DATA_W  upstream row data.
REQ-012 o_ready  out  1  upstream may transfer this cycle.
REQ-013 o_valid  out  N_PATH  one-hot per-path row valid.
REQ-014 o_data  out  DATA_W  registered row data, shared by all paths.
REQ-015 i_ready  in  N_PATH  per-path downstream ready.
REQ-016 o_busy  out  1  high whenever state is not IDLE.
REQ-017 o_done  out  1  one-cycle pulse at block completion.
REQ-018 o_err  out  1  sticky: a block started with i_sel >= N_PATH.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-020 IDLE: on i_start, latch sel_r=i_sel, rows_r=i_rows, cnt=0, go RUN; o_ready=0.
REQ-021 RUN: o_ready = !out_vld | i_ready[sel_r]; row accepted when i_valid & o_ready.
REQ-022 Accepted row loads o_data and sets out_vld the next cycle (latency 1); cnt increments per accepted row.
REQ-023 Accepting the row with cnt==rows_r SHALL move to DRAIN; the counter does not wrap within a block.
REQ-024 DRAIN: o_ready=0; when out_vld=0, or out_vld & i_ready[sel_r], pulse o_done and go IDLE the next cycle.
REQ-025 o_valid[k] = out_vld & (sel_r==k); all bits 0 otherwise.
REQ-026 out_vld SHALL clear on a downstream handshake with no new accept, and SHALL hold with o_data stable while i_ready[sel_r]=0.
REQ-027 i_start outside IDLE SHALL be ignored; sel_r/rows_r are constant for the whole block.
REQ-028 i_valid in IDLE or DRAIN SHALL not be accepted and SHALL not change state.
REQ-029 i_sel >= N_PATH SHALL set o_err; the block's rows are still consumed (o_ready per RUN with i_ready treated as 1) but o_valid stays 0; o_done still pulses.
REQ-030 i_rows=0 SHALL be a legal single-row block.
REQ-031 Throughput SHALL be one row per cycle while the selected i_ready=1.

Reset
REQ-032 rstn low SHALL asynchronously force IDLE, cnt=0, sel_r=0, rows_r=0, out_vld=0, o_data=0, o_done=0, o_err=0, o_busy=0, o_valid=0.
REQ-033 Reset mid-block SHALL discard the block with no o_done; the first i_start after rstn deasserts starts a fresh block.

Structure
REQ-034 State encoding constants and the path-index constants (PATH_INV=0, PATH_FWD=1) SHALL live in the shared tq package.
REQ-035 SHALL be a single module with no sub-modules; the output register is inline.

Verification
REQ-036 N_PATH=2, start sel=1 rows=3, i_valid=1 for 4 cycles, i_ready=2'b11 -> o_valid=2'b10 for 4 consecutive cycles, data in order; o_done 1 cycle after the last beat; o_valid[0]=0 throughout.
REQ-037 sel=0 rows=7, i_ready[0] held low for cycles 3-5 -> o_data stable and o_ready=0 while stalled; 8 beats delivered with no loss or duplication.
REQ-038 rows=0 with a single beat -> exactly one o_valid pulse, then o_done, then IDLE; o_busy is high for exactly 3 cycles.
REQ-039 N_PATH=4, sel=5 -> o_err=1, rows consumed, o_valid=0, o_done pulses; o_err stays set until rstn.
REQ-040 rstn low after 2 of 6 rows -> all outputs 0 immediately; no o_done; a new start with rows=1 completes normally.
REQ-041 i_start pulsed in RUN with a different sel -> ignored; the current block completes on its original path.

Source files
------------

// File: rtl/tq_path_ctl_pkg.sv
// Shared definitions for the tq row-path steering controller.
package tq_path_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tq_state_e;

    localparam int PATH_INV = 0;
    localparam int PATH_FWD = 1;

    function automatic int sel_width(input int n_path);
        return (n_path > 1) ? $clog2(n_path) : 1;
    endfunction

endpackage

// File: rtl/tq_path_ctl.sv
// Steers a block of rows from one upstream port to one of N_PATH downstream
// paths through a single output register, with block-level done/err status.
module tq_path_ctl
    import tq_path_ctl_pkg::*;
#(
    parameter int N_PATH = 2,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 5,
    localparam int SEL_W = sel_width(N_PATH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [CNT_W-1:0]  i_rows,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic [N_PATH-1:0] o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic [N_PATH-1:0] i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    tq_state_e         state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  rows_q, rows_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic rdy_sel;
    logic dn_hs;
    logic accept;

    // An out-of-range path has no consumer, so it behaves as always ready.
    always_comb begin
        rdy_sel = 1'b1;
        for (int k = 0; k < N_PATH; k++) begin
            if (sel_q == SEL_W'(k)) rdy_sel = i_ready[k];
        end
    end

    assign dn_hs   = out_vld_q & rdy_sel;
    assign o_ready = (state_q == ST_RUN) & (~out_vld_q | rdy_sel);
    assign accept  = i_valid & o_ready;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rows_d    = rows_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = err_q;
        out_vld_d = out_vld_q;
        data_d    = data_q;

        if (accept) begin
            out_vld_d = 1'b1;
            data_d    = i_data;
        end else if (dn_hs) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    sel_d   = i_sel;
                    rows_d  = i_rows;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    if (32'(i_sel) >= N_PATH) err_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (cnt_q == rows_q) state_d = ST_DRAIN;
                    else                 cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (~out_vld_q | dn_hs) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            rows_q    <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rows_q    <= rows_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        o_valid = '0;
        for (int k = 0; k < N_PATH; k++) begin
            o_valid[k] = out_vld_q & (sel_q == SEL_W'(k));
        end
    end

    assign o_data = data_q;
    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_tq_path_ctl.sv
// Scoreboard bench for tq_path_ctl: driver pushes expected beats, monitor pops on handshakes.
module tb_tq_path_ctl;

    localparam int N_PATH = 3;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;
    localparam int SEL_W  = 2;

    typedef struct packed {
        logic [SEL_W-1:0]  path;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              i_start = 1'b0;
    logic [SEL_W-1:0]  i_sel = '0;
    logic [CNT_W-1:0]  i_rows = '0;
    logic              i_valid = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              o_ready;
    logic [N_PATH-1:0] o_valid;
    logic [DATA_W-1:0] o_data;
    logic [N_PATH-1:0] i_ready = '1;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    tq_path_ctl #(.N_PATH(N_PATH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_sel(i_sel), .i_rows(i_rows),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_valid(o_valid),
        .o_data(o_data), .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_hs = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every downstream handshake.
    always @(negedge clk) begin
        cyc++;
        if (o_busy) busy_cnt++;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_valid != '0) begin
            chk("onehot", 64'($onehot(o_valid)), 64'd1);
            for (int k = 0; k < N_PATH; k++) begin
                if (o_valid[k] && i_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(o_data), 64'hDEAD_0000);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("beat_path", 64'(k), 64'(e.path));
                        chk("beat_data", 64'(o_data), 64'(e.data));
                    end
                    last_hs = cyc;
                end
            end
        end
    end

    task automatic run_block(input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] rows,
                             input logic [DATA_W-1:0] base, input int gap,
                             input int stall_lo, input int stall_hi,
                             input int restart_at, input int abort_at, output int ok);
        int b, c, nbeats;
        logic acc;
        logic is_err;
        b = 0; c = 0; nbeats = int'(rows) + 1; ok = 0;
        is_err = (int'(sel) >= N_PATH);
        busy_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        i_start = 1'b1; i_sel = sel; i_rows = rows; i_valid = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (abort_at >= 0 && b == abort_at) begin
                ok = 1;
                return;
            end
            i_ready = is_err ? '0 : '1;
            if (c >= stall_lo && c <= stall_hi) i_ready[0] = 1'b0;
            i_valid = (c >= gap) && (b < nbeats);
            i_data  = base + DATA_W'(b);
            i_start = (restart_at >= 0) && (b == restart_at) && i_valid;
            i_sel   = i_start ? (sel ^ 2'b01) : sel;
            @(negedge clk);
            if (c >= stall_lo && c <= stall_hi) begin
                chk("stall_ready", 64'(o_ready), 64'd0);
                chk("stall_data", 64'(o_data), 64'(base + DATA_W'(stall_lo - 1)));
            end
            if (is_err) chk("err_no_valid", 64'(o_valid), 64'd0);
            acc = i_valid & o_ready;
            if (acc && !is_err) exp_q.push_back('{path: sel, data: i_data});
            @(posedge clk); #1;
            i_start = 1'b0;
            if (acc) b++;
            c++;
            if (b == nbeats && !o_busy) begin
                ok = 1;
                break;
            end
        end
        i_valid = 1'b0;
        i_ready = '1;
        if (!ok) chk("block_timeout", 64'(b), 64'(nbeats));
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int ok;
        #12;
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        rstn = 1'b1;

        // Four beats on the forward path, full throughput.
        run_block(2'd1, 5'd3, 32'h1000, 0, -1, -1, -1, -1, ok);
        chk("fwd_done_cnt", 64'(done_cnt), 64'd1);
        chk("fwd_done_time", 64'(done_cyc), 64'(last_hs + 1));
        chk("fwd_busy", 64'(busy_cnt), 64'd5);
        chk("fwd_drained", 64'(exp_q.size()), 64'd0);

        // Start pulse mid-block with a different path must be ignored.
        run_block(2'd1, 5'd3, 32'h2000, 0, -1, -1, 1, -1, ok);
        chk("restart_done_cnt", 64'(done_cnt), 64'd1);
        chk("restart_drained", 64'(exp_q.size()), 64'd0);

        // Eight beats on path 0 with a three-cycle downstream stall.
        run_block(2'd0, 5'd7, 32'h3000, 0, 3, 5, -1, -1, ok);
        chk("stall_done_cnt", 64'(done_cnt), 64'd1);
        chk("stall_busy", 64'(busy_cnt), 64'd12);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Single-row block after one idle RUN cycle.
        run_block(2'd0, 5'd0, 32'h4000, 1, -1, -1, -1, -1, ok);
        chk("single_done_cnt", 64'(done_cnt), 64'd1);
        chk("single_busy", 64'(busy_cnt), 64'd3);
        chk("single_idle", 64'(o_busy), 64'd0);
        chk("single_drained", 64'(exp_q.size()), 64'd0);

        // Out-of-range path: rows consumed, nothing delivered, err sticky.
        run_block(2'd3, 5'd2, 32'h5000, 0, -1, -1, -1, -1, ok);
        chk("err_set", 64'(o_err), 64'd1);
        chk("err_done_cnt", 64'(done_cnt), 64'd1);
        chk("err_busy", 64'(busy_cnt), 64'd4);
        run_block(2'd1, 5'd1, 32'h6000, 0, -1, -1, -1, -1, ok);
        chk("err_sticky", 64'(o_err), 64'd1);
        chk("after_err_done", 64'(done_cnt), 64'd1);

        // Reset after two of six rows.
        run_block(2'd0, 5'd5, 32'h7000, 0, -1, -1, -1, 2, ok);
        chk("abort_reached", 64'(ok), 64'd1);
        i_valid = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(o_ready), 64'd0);
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_data", 64'(o_data), 64'd0);
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_err", 64'(o_err), 64'd0);
        exp_q.delete();
        @(posedge clk); #2;
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
        run_block(2'd1, 5'd1, 32'h8000, 0, -1, -1, -1, -1, ok);
        chk("post_rst_done", 64'(done_cnt), 64'd1);
        chk("post_rst_busy", 64'(busy_cnt), 64'd3);
        chk("post_rst_drained", 64'(exp_q.size()), 64'd0);
        chk("post_rst_err", 64'(o_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
